// File: rtl/n_bit_seq_div_pkg.sv
// Shared constants for the sequential arithmetic blocks: FSM encodings
// and counter sizing for the restoring divider.
package n_bit_seq_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } div_state_t;

    // Iteration counter width: must count 0..N-1 with one bit of headroom.
    function automatic int div_cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/n_bit_pipo.sv
// Parallel-in / parallel-out register with load enable and synchronous clear.
module n_bit_pipo #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Clear has priority; otherwise capture d when load is high.
    always_ff @(posedge clk) begin
        if (!clr_n)
            q <= '0;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/n_bit_seq_div.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
// Operands are loaded over a shared bus into two holding registers; a
// start copies them into the working registers so the holding registers
// can be reloaded while the result is on display.
module n_bit_seq_div
    import n_bit_seq_div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic [N-1:0] data_in,
    input  logic         load_a,
    input  logic         load_b,
    input  logic         start,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero
);

    localparam int CW = div_cnt_width(N);

    div_state_t      state, state_nxt;
    logic [N-1:0]    a_q, b_q;
    logic [N-1:0]    rem_w, q_w, div_w;
    logic [CW-1:0]   cnt;
    logic            dbz_q;
    logic            accept;
    logic            load_a_en, load_b_en;
    logic            b_is_zero;
    logic [N:0]      rem_shift;
    logic signed [N:0] trial;

    // Loads are locked out while a division is running.
    assign load_a_en = load_a & ~busy;
    assign load_b_en = load_b & ~busy;
    assign b_is_zero = (b_q == '0);

    n_bit_pipo #(.N(N)) u_reg_a (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (load_a_en),
        .d     (data_in),
        .q     (a_q)
    );

    n_bit_pipo #(.N(N)) u_reg_b (
        .clk   (clk),
        .clr_n (clr_n),
        .load  (load_b_en),
        .d     (data_in),
        .q     (b_q)
    );

    // Shift {rem, q} left by one; the partial remainder gains q's MSB.
    // rem < divisor always holds, so N+1 bits are enough for the trial
    // subtraction and its top bit is a valid sign.
    assign rem_shift = {rem_w, q_w[N-1]};
    assign trial     = $signed(rem_shift - {1'b0, div_w});

    // State register.
    always_ff @(posedge clk) begin
        if (!clr_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = b_is_zero ? ST_DONE : ST_DIVIDE;
                end
            end
            ST_DIVIDE: begin
                busy = 1'b1;
                if (cnt == CW'(N - 1))
                    state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Working registers: capture operands on an accepted start, then one
    // restoring step per DIVIDE cycle.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rem_w <= '0;
            q_w   <= '0;
            div_w <= '0;
            cnt   <= '0;
            dbz_q <= 1'b0;
        end else if (accept) begin
            cnt   <= '0;
            div_w <= b_q;
            if (b_is_zero) begin
                q_w   <= '1;
                rem_w <= a_q;
                dbz_q <= 1'b1;
            end else begin
                q_w   <= a_q;
                rem_w <= '0;
                dbz_q <= 1'b0;
            end
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (!trial[N]) begin
                rem_w <= trial[N-1:0];
                q_w   <= {q_w[N-2:0], 1'b1};
            end else begin
                rem_w <= rem_shift[N-1:0];
                q_w   <= {q_w[N-2:0], 1'b0};
            end
        end
    end

    assign quotient    = q_w;
    assign remainder   = rem_w;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_n_bit_seq_div.sv
// Scoreboard bench for n_bit_seq_div (N = 8): the driver pushes expected
// results with the cycle they are due; a negedge monitor pops and compares.
module tb_n_bit_seq_div;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         clr_n;
    logic [N-1:0] data_in;
    logic         load_a, load_b, start;
    logic [N-1:0] quotient, remainder;
    logic         busy, done, div_by_zero;

    typedef struct {
        int q;
        int r;
        int dbz;
        int busy_n;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   busy_cnt = 0;
    logic done_d = 1'b0;

    n_bit_seq_div #(.N(N)) u_dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .data_in     (data_in),
        .load_a      (load_a),
        .load_b      (load_b),
        .start       (start),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input bit la, input bit lb, input int val);
        load_a  = la;
        load_b  = lb;
        data_in = N'(val);
        step();
        load_a  = 1'b0;
        load_b  = 1'b0;
    endtask

    // Raise start for one edge, optionally with a simultaneous load_a.
    // A nonzero divisor finishes N edges after the sampling edge; a zero
    // divisor is in DONE right after the sampling edge.
    task automatic issue(input bit push, input bit la, input int d,
                         input int q, input int r, input int dbz);
        exp_t e;
        start   = 1'b1;
        load_a  = la;
        data_in = N'(d);
        if (push) begin
            e.q      = q;
            e.r      = r;
            e.dbz    = dbz;
            e.busy_n = dbz ? 0 : N;
            e.due    = cyc + 1 + e.busy_n;
            sb.push_back(e);
        end
        step();
        start  = 1'b0;
        load_a = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    // Monitor: compare the head of the scoreboard on its due cycle.
    always @(negedge clk) begin
        if (!clr_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (sb.size() != 0 && sb[0].busy_n > 0 && cyc == sb[0].due - 1)
                chk("done_early", int'(done), 0);
            if (sb.size() != 0 && cyc == sb[0].due) begin
                exp_t e;
                e = sb.pop_front();
                chk("done",        int'(done),        1);
                chk("quotient",    int'(quotient),    e.q);
                chk("remainder",   int'(remainder),   e.r);
                chk("div_by_zero", int'(div_by_zero), e.dbz);
                chk("busy_cycles", busy_cnt,          e.busy_n);
                busy_cnt = 0;
            end else if (done && !done_d && sb.size() == 0) begin
                chk("unexpected_done", int'(done), 0);
            end
        end
        done_d = done;
    end

    initial begin
        clr_n   = 1'b0;
        data_in = '0;
        load_a  = 1'b0;
        load_b  = 1'b0;
        start   = 1'b0;
        step();
        step();
        chk("rst_quotient",  int'(quotient),    0);
        chk("rst_remainder", int'(remainder),   0);
        chk("rst_busy",      int'(busy),        0);
        chk("rst_done",      int'(done),        0);
        chk("rst_dbz",       int'(div_by_zero), 0);
        clr_n = 1'b1;
        step();

        // Basic division and boundary operands.
        load(1, 0, 200); load(0, 1, 7);
        issue(1, 0, 0, 28, 4, 0);    wait_empty();
        load(1, 0, 255); load(0, 1, 1);
        issue(1, 0, 0, 255, 0, 0);   wait_empty();
        load(1, 0, 5);   load(0, 1, 9);
        issue(1, 0, 0, 0, 5, 0);     wait_empty();
        load(1, 1, 255);
        issue(1, 0, 0, 1, 0, 0);     wait_empty();

        // Divide by zero, then a normal division clears the flag.
        load(1, 0, 13);  load(0, 1, 0);
        issue(1, 0, 0, 255, 13, 1);  wait_empty();
        load(0, 1, 3);
        issue(1, 0, 0, 4, 1, 0);     wait_empty();

        // Reset in the middle of a division: no result, everything cleared.
        load(1, 0, 100); load(0, 1, 3);
        issue(0, 0, 0, 0, 0, 0);
        step(); step(); step();
        clr_n = 1'b0;
        step();
        chk("abort_quotient",  int'(quotient),    0);
        chk("abort_remainder", int'(remainder),   0);
        chk("abort_busy",      int'(busy),        0);
        chk("abort_done",      int'(done),        0);
        chk("abort_dbz",       int'(div_by_zero), 0);
        clr_n = 1'b1;
        repeat (12) step();
        chk("abort_no_done", int'(done), 0);
        load(1, 0, 100); load(0, 1, 3);
        issue(1, 0, 0, 33, 1, 0);    wait_empty();

        // load_a and start while busy are ignored.
        issue(1, 0, 0, 33, 1, 0);
        step(); step();
        issue(0, 1, 50, 0, 0, 0);
        wait_empty();
        issue(1, 0, 0, 33, 1, 0);    wait_empty();

        // Start with a simultaneous load divides the old dividend.
        load(1, 0, 90);  load(0, 1, 9);
        issue(1, 1, 60, 10, 0, 0);   wait_empty();
        issue(1, 0, 0, 6, 6, 0);     wait_empty();

        repeat (3) step();
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/n_bit_seq_div.md
N_BIT_SEQ_DIV -- requirements
Module: n_bit_seq_div

Interface
REQ-001 The module SHALL have parameter N, default 8, giving the operand width in bits (N >= 2).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port clr_n, input, 1, SHALL be the reset; reset is synchronous and active-low.
REQ-004 Port data_in, input, N, SHALL carry the shared operand bus.
REQ-005 Port load_a, input, 1, SHALL load data_in into the dividend register.
REQ-006 Port load_b, input, 1, SHALL load data_in into the divisor register.
REQ-007 Port start, input, 1, SHALL request a division of the stored operands.
REQ-008 Port quotient, output, N, SHALL carry the unsigned quotient.
REQ-009 Port remainder, output, N, SHALL carry the unsigned remainder.
REQ-010 Port busy, output, 1, SHALL be high while a division is in progress.
REQ-011 Port done, output, 1, SHALL be high while quotient and remainder are valid.
REQ-012 Port div_by_zero, output, 1, SHALL flag that the last result used a zero divisor.

Function
REQ-013 The block SHALL implement unsigned restoring division with one quotient bit per cycle, MSB first.
REQ-014 The FSM SHALL have the states IDLE, DIVIDE and DONE.
REQ-015 In IDLE or DONE, start SHALL copy the operands into working registers, clear the counter, clear done, and go to DIVIDE; busy then goes high.
REQ-016 In DIVIDE, each cycle SHALL compute shift {rem, q} left by 1, then trial = rem - divisor, using an N+1-bit trial subtraction; if trial >= 0, rem <= trial and the new q LSB = 1, otherwise the new q LSB = 0.
REQ-017 After exactly N DIVIDE iterations the FSM SHALL enter DONE; done rises on the Nth rising edge after the edge that sampled start.
REQ-018 DONE SHALL hold quotient, remainder and done until the next accepted start or a reset.
REQ-019 If the divisor is 0 at start, the FSM SHALL go directly to DONE on the next edge with quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-020 div_by_zero SHALL clear on the next accepted start that has a nonzero divisor.
REQ-021 load_a, load_b and start SHALL be ignored while busy.
REQ-022 If start coincides with load_a or load_b, start SHALL use the register contents held before that edge, and the load SHALL still update the register.
REQ-023 If load_a and load_b are both high, both registers SHALL take data_in.
REQ-024 quotient and remainder SHALL be driven from the working registers and are defined only while done = 1.

Reset
REQ-025 When clr_n is low at a rising edge, the block SHALL force state IDLE, clear the operand, working and counter registers, and set quotient, remainder, busy, done and div_by_zero to 0.
REQ-026 Reset SHALL override every other input, including during DIVIDE; an aborted division SHALL produce no done pulse.

Structure
REQ-027 The FSM state encodings and the counter width (clog2(N)+1) SHALL be defined in a shared include file with the codebase's other arithmetic-block constants.
REQ-028 The two operand registers SHALL each be an instance of the existing n_bit_pipo register sub-module.
REQ-029 The rest of the logic SHALL be a single datapath plus FSM in n_bit_seq_div, with no further sub-modules.

Verification
REQ-030 With N=8, dividend 200 and divisor 7, start SHALL give quotient 28 and remainder 4, with done high 8 edges after start and busy high for those 8 cycles.
REQ-031 With N=8, the cases 255/1 -> 255 r0, 5/9 -> 0 r5 and 255/255 -> 1 r0 SHALL each complete in 8 cycles.
REQ-032 With dividend 13 and divisor 0, start SHALL give done after 1 edge with quotient 0xFF, remainder 13 and div_by_zero = 1; a following 13/3 SHALL give 4 r1 with div_by_zero = 0.
REQ-033 clr_n low at iteration 4 of 100/3 SHALL give state IDLE and all outputs 0 at the next edge, with no done; a restarted 100/3 SHALL give 33 r1.
REQ-034 During 100/3, load_a = 50 and start SHALL be ignored: the result SHALL be 33 r1 and the dividend register SHALL still hold 100.
REQ-035 load_a = 60 with start on the same edge, after a stored dividend of 90 and divisor 9, SHALL divide 90 (result 10 r0); the next start SHALL divide 60 (result 6 r6).
